pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle main decoder. Decodes the RV opcode in ID,

---
 rtl/pipe_ctrl_unit.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Pipelined control unit. Decodes the RV opcode of the instruction in ID and
//   carries its control bundle through the ID/EX, EX/MEM and MEM/WB registers.
//   It detects load-use hazards and applies the external stall and flush.
//   Every stage output is a field of that stage's register, so a bundle
//   appears at EX one cycle after decode, at MEM after two and at WB after three.
//
// Ports
//   clk_i, rst_i             clock (rising edge), synchronous reset (active high)
//   instr_op_i               opcode of the instruction in ID
//   rs1_i, rs2_i, rd_i       register indices of the instruction in ID
//   stall_i                  freezes all three stage registers
//   flush_i                  replaces the ID instruction with a bubble
//   hold_if_o                load-use hazard: hold PC and IF/ID (combinational)
//   ex_*                     ALU/branch controls, illegal flag and rd held in ID/EX
//   mem_*                    memory read/write strobes held in EX/MEM
//   wb_*                     write-back controls and rd held in MEM/WB
module pipe_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter bit EN_EXT_OPS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        instr_op_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hold_if_o,
  output logic [1:0]        ex_ALU_op_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_PCSrcA_o,
  output logic              ex_Branch_o,
  output logic              ex_Jump_o,
  output logic              ex_JumpReg_o,
  output logic              ex_illegal_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              mem_MemRead_o,
  output logic              mem_MemWrite_o,
  output logic              wb_RegWrite_o,
  output logic              wb_MemtoReg_o,
  output logic              wb_Link_o,
  output logic [REG_AW-1:0] wb_rd_o
);

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_OPIMM = 7'b0010011,
    OP_STORE = 7'b0100011,
    OP_REG   = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111
  } opcodeT;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  // One record per stage; an all-zero record is the bubble.
  typedef struct packed {
    logic [1:0]        aluOp;
    logic              aluSrc;
    logic              pcSrcA;
    logic              branch;
    logic              jump;
    logic              jumpReg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memtoReg;
    logic              link;
    logic              illegal;
    logic [REG_AW-1:0] rd;
  } stageT;

  stageT dec;
  stageT idEx, exMem, memWb;
  logic  usesRs1, usesRs2;
  logic  hazard;

  // ---------------------------------------------------------------- decode
  always_comb begin
    // NOTE: every field gets a default before the case, so opcodes that set
    // only some controls cannot leave the rest holding a value (no latch).
    dec     = '0;
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    case (instr_op_i)
      OP_LOAD: begin
        dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.memRead = 1'b1;
        dec.memtoReg = 1'b1; usesRs1 = 1'b1;
      end
      OP_OPIMM: begin
        dec.aluSrc = 1'b1; dec.regWrite = 1'b1; usesRs1 = 1'b1;
      end
      OP_STORE: begin
        dec.aluSrc = 1'b1; dec.memWrite = 1'b1;
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      OP_REG: begin
        dec.aluOp = ALU_FUNCT; dec.regWrite = 1'b1;
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.aluOp = ALU_SUB; dec.branch = 1'b1;
        usesRs1 = 1'b1; usesRs2 = 1'b1;
      end
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        if (EN_EXT_OPS) begin
          case (instr_op_i)
            OP_JAL: begin
              dec.jump = 1'b1; dec.regWrite = 1'b1; dec.link = 1'b1;
            end
            OP_JALR: begin
              dec.aluSrc = 1'b1; dec.jump = 1'b1; dec.jumpReg = 1'b1;
              dec.regWrite = 1'b1; dec.link = 1'b1; usesRs1 = 1'b1;
            end
            OP_LUI: begin
              dec.aluOp = ALU_PASSB; dec.aluSrc = 1'b1; dec.regWrite = 1'b1;
            end
            default: begin // AUIPC
              dec.aluOp = ALU_ADD; dec.aluSrc = 1'b1; dec.pcSrcA = 1'b1;
              dec.regWrite = 1'b1;
            end
          endcase
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd = rd_i;
  end

  // ------------------------------------------------------- load-use hazard
  // A load in EX cannot forward its data to the ID instruction in time.
  assign hazard = idEx.memRead && (idEx.rd != '0) &&
                  ((usesRs1 && (rs1_i == idEx.rd)) ||
                   (usesRs2 && (rs2_i == idEx.rd)));
  assign hold_if_o = hazard;

  // ------------------------------------------------------- stage registers
  always_ff @(posedge clk_i) begin
    // NOTE: the stage records are ordinary flops, so reset clears every one of
    // them and any in-flight bundle is discarded rather than left to drain.
    if (rst_i) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else if (!stall_i) begin
      // NOTE: non-blocking, so each stage takes the value its predecessor held
      // before this edge and the three registers shift together.
      exMem <= idEx;
      memWb <= exMem;
      idEx  <= (flush_i || hazard) ? '0 : dec;
    end
  end

  // --------------------------------------------------------------- outputs
  assign ex_ALU_op_o    = idEx.aluOp;
  assign ex_ALUSrc_o    = idEx.aluSrc;
  assign ex_PCSrcA_o    = idEx.pcSrcA;
  assign ex_Branch_o    = idEx.branch;
  assign ex_Jump_o      = idEx.jump;
  assign ex_JumpReg_o   = idEx.jumpReg;
  assign ex_illegal_o   = idEx.illegal;
  assign ex_rd_o        = idEx.rd;
  assign mem_MemRead_o  = exMem.memRead;
  assign mem_MemWrite_o = exMem.memWrite;
  assign wb_RegWrite_o  = memWb.regWrite;
  assign wb_MemtoReg_o  = memWb.memtoReg;
  assign wb_Link_o      = memWb.link;
  assign wb_rd_o        = memWb.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
//   Self-checking bench for pipe_ctrl_unit. A second instance built without
//   the extended opcodes shares the inputs of the main instance.
module tb_pipe_ctrl_unit;

  logic       clk_i = 1'b0;
  logic       rst_i, stall_i, flush_i;
  logic [6:0] instr_op_i;
  logic [4:0] rs1_i, rs2_i, rd_i;

  logic       hold_if_o, ex_ALUSrc_o, ex_PCSrcA_o, ex_Branch_o, ex_Jump_o;
  logic       ex_JumpReg_o, ex_illegal_o, mem_MemRead_o, mem_MemWrite_o;
  logic       wb_RegWrite_o, wb_MemtoReg_o, wb_Link_o;
  logic [1:0] ex_ALU_op_o;
  logic [4:0] ex_rd_o, wb_rd_o;

  logic       hold0, exAluSrc0, exPcSrcA0, exBranch0, exJump0, exJumpReg0, exIll0;
  logic       memRead0, memWrite0, wbRegWrite0, wbMemtoReg0, wbLink0;
  logic [1:0] exAluOp0;
  logic [4:0] exRd0, wbRd0;

  pipe_ctrl_unit #(.REG_AW(5), .EN_EXT_OPS(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .stall_i(stall_i), .flush_i(flush_i), .hold_if_o(hold_if_o),
    .ex_ALU_op_o(ex_ALU_op_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_PCSrcA_o(ex_PCSrcA_o),
    .ex_Branch_o(ex_Branch_o), .ex_Jump_o(ex_Jump_o), .ex_JumpReg_o(ex_JumpReg_o),
    .ex_illegal_o(ex_illegal_o), .ex_rd_o(ex_rd_o),
    .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o),
    .wb_Link_o(wb_Link_o), .wb_rd_o(wb_rd_o)
  );

  pipe_ctrl_unit #(.REG_AW(5), .EN_EXT_OPS(1'b0)) dutNoExt (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .stall_i(stall_i), .flush_i(flush_i), .hold_if_o(hold0),
    .ex_ALU_op_o(exAluOp0), .ex_ALUSrc_o(exAluSrc0), .ex_PCSrcA_o(exPcSrcA0),
    .ex_Branch_o(exBranch0), .ex_Jump_o(exJump0), .ex_JumpReg_o(exJumpReg0),
    .ex_illegal_o(exIll0), .ex_rd_o(exRd0),
    .mem_MemRead_o(memRead0), .mem_MemWrite_o(memWrite0),
    .wb_RegWrite_o(wbRegWrite0), .wb_MemtoReg_o(wbMemtoReg0),
    .wb_Link_o(wbLink0), .wb_rd_o(wbRd0)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] LD = 7'b0000011, OPIMM = 7'b0010011, SD = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011, BEQ = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  // ctl = {ALU_op[1:0], ALUSrc, PCSrcA, Branch, Jump, JumpReg,
  //        RegWrite, MemRead, MemWrite, MemtoReg, Link}
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] ctl;
    logic        ill;
  } vecT;

  typedef struct {
    logic [11:0] ctl;
    logic        ill;
    logic [4:0]  rd;
  } stageT;

  vecT   tbl[10];
  stageT m[3];
  int    nChecks = 0;
  int    nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: look the opcode up in the specification table.
  function automatic void refDecode(input logic [6:0] op, input bit en,
                                    output logic [11:0] ctl, output logic ill,
                                    output logic u1, output logic u2);
    ctl = '0;
    ill = 1'b1;
    for (int i = 0; i < 10; i++)
      if (tbl[i].op == op && !tbl[i].ill) begin
        ctl = tbl[i].ctl;
        ill = 1'b0;
      end
    if (!en && (op inside {JAL, JALR, LUI, AUIPC})) begin
      ctl = '0;
      ill = 1'b1;
    end
    u1 = !ill && !(op inside {LUI, AUIPC, JAL});
    u2 = !ill && (op inside {RR, SD, BEQ});
  endfunction

  task automatic checkStages(input string tag);
    check({tag, "_ex"},
          32'({ex_ALU_op_o, ex_ALUSrc_o, ex_PCSrcA_o, ex_Branch_o, ex_Jump_o,
               ex_JumpReg_o, ex_illegal_o, ex_rd_o}),
          32'({m[0].ctl[11:5], m[0].ill, m[0].rd}));
    check({tag, "_mem"}, 32'({mem_MemRead_o, mem_MemWrite_o}), 32'(m[1].ctl[3:2]));
    check({tag, "_wb"},
          32'({wb_RegWrite_o, wb_MemtoReg_o, wb_Link_o, wb_rd_o}),
          32'({m[2].ctl[4], m[2].ctl[1:0], m[2].rd}));
  endtask

  // One clock: drive ID inputs, check the hazard output, clock, then compare
  // all three stages with the model. Called at posedge + 1.
  task automatic step(input string tag, input logic [6:0] op,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic st, input logic fl, input logic rs,
                      output logic holdSeen);
    logic [11:0] ctl;
    logic        ill, u1, u2, haz;
    stageT       nxt[3];
    instr_op_i = op; rs1_i = a; rs2_i = b; rd_i = d;
    stall_i = st; flush_i = fl; rst_i = rs;
    #1;
    refDecode(op, 1'b1, ctl, ill, u1, u2);
    haz = m[0].ctl[3] && (m[0].rd != 0) && ((u1 && a == m[0].rd) || (u2 && b == m[0].rd));
    holdSeen = hold_if_o;
    check({tag, "_hold"}, 32'(hold_if_o), 32'(haz));
    nxt = m;
    if (rs) begin
      for (int i = 0; i < 3; i++) nxt[i] = '{ctl: '0, ill: 1'b0, rd: '0};
    end else if (!st) begin
      nxt[2] = m[1];
      nxt[1] = m[0];
      if (fl || haz) nxt[0] = '{ctl: '0, ill: 1'b0, rd: '0};
      else           nxt[0] = '{ctl: ctl, ill: ill, rd: d};
    end
    @(posedge clk_i);
    #1;
    m = nxt;
    checkStages(tag);
  endtask

  logic h;

  initial begin
    tbl[0] = '{LD,    5'd2, 5'd3, 5'd7,  12'b00_1_0_0_0_0_1_1_0_1_0, 1'b0};
    tbl[1] = '{OPIMM, 5'd2, 5'd3, 5'd11, 12'b00_1_0_0_0_0_1_0_0_0_0, 1'b0};
    tbl[2] = '{SD,    5'd2, 5'd3, 5'd12, 12'b00_1_0_0_0_0_0_0_1_0_0, 1'b0};
    tbl[3] = '{RR,    5'd2, 5'd3, 5'd13, 12'b10_0_0_0_0_0_1_0_0_0_0, 1'b0};
    tbl[4] = '{BEQ,   5'd2, 5'd3, 5'd14, 12'b01_0_0_1_0_0_0_0_0_0_0, 1'b0};
    tbl[5] = '{JAL,   5'd2, 5'd3, 5'd15, 12'b00_0_0_0_1_0_1_0_0_0_1, 1'b0};
    tbl[6] = '{JALR,  5'd2, 5'd3, 5'd16, 12'b00_1_0_0_1_1_1_0_0_0_1, 1'b0};
    tbl[7] = '{LUI,   5'd2, 5'd3, 5'd17, 12'b11_1_0_0_0_0_1_0_0_0_0, 1'b0};
    tbl[8] = '{AUIPC, 5'd2, 5'd3, 5'd18, 12'b00_1_1_0_0_0_1_0_0_0_0, 1'b0};
    tbl[9] = '{7'b1111111, 5'd2, 5'd3, 5'd19, 12'b0, 1'b1};

    // Initial reset: state is unknown until the first edge.
    instr_op_i = RR; rs1_i = '0; rs2_i = '0; rd_i = 5'd1;
    stall_i = 1'b0; flush_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) m[i] = '{ctl: '0, ill: 1'b0, rd: '0};

    // Reset held two cycles with an R-type in ID, then released.
    step("rst", RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, h);
    step("rst", RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, h);
    check("rst_all_zero", 32'({ex_ALU_op_o, ex_illegal_o, ex_rd_o, mem_MemRead_o,
                               wb_RegWrite_o, wb_rd_o, hold_if_o}), 32'd0);
    step("rel", RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, h);
    check("rel_ex_aluop", 32'(ex_ALU_op_o), 32'(2'b10));
    step("rel", RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, h);
    step("rel", RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, h);
    check("rel_wb_regwrite", 32'(wb_RegWrite_o), 32'd1);

    // Table stream: every opcode, EX must match the table one cycle later.
    for (int i = 0; i < 10; i++) begin
      step("tbl", tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 1'b0, 1'b0, 1'b0, h);
      check($sformatf("tbl%0d_ex", i),
            32'({ex_ALU_op_o, ex_ALUSrc_o, ex_PCSrcA_o, ex_Branch_o, ex_Jump_o,
                 ex_JumpReg_o, ex_illegal_o}),
            32'({tbl[i].ctl[11:5], tbl[i].ill}));
    end
    for (int i = 0; i < 3; i++) step("drain", OPIMM, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, h);

    // Load-use with rd=5: one hold cycle, bubble at EX, then R at EX.
    step("lu", LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, h);
    step("lu", RR, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, h);
    check("lu_hold", 32'(h), 32'd1);
    check("lu_bubble", 32'({ex_ALU_op_o, ex_rd_o}), 32'd0);
    step("lu", RR, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, h);
    check("lu_hold_clear", 32'(h), 32'd0);
    check("lu_r_at_ex", 32'({ex_ALU_op_o, ex_rd_o}), 32'({2'b10, 5'd6}));
    // Same pattern with rd=0: never a hazard.
    step("lu0", LD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, h);
    step("lu0", RR, 5'd1, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, h);
    check("lu0_no_hold", 32'(h), 32'd0);

    // Flush kills a JALR in ID while the older load proceeds.
    step("fl", LD, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, h);
    step("fl", JALR, 5'd1, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, h);
    check("fl_no_jump", 32'(ex_Jump_o), 32'd0);
    check("fl_ld_memread", 32'(mem_MemRead_o), 32'd1);

    // Stall for 3 cycles with flush and a load-use hazard pending.
    step("st", LD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, h);
    for (int i = 0; i < 3; i++) begin
      step("st", RR, 5'd4, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, h);
      check("st_hold", 32'(h), 32'd1);
      check("st_frozen_ex", 32'({ex_rd_o, ex_ALUSrc_o}), 32'({5'd4, 1'b1}));
    end
    step("st", RR, 5'd4, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, h);
    check("st_flush_applied", 32'({ex_rd_o, mem_MemRead_o}), 32'({5'd0, 1'b1}));

    // Extended opcodes disabled: JAL is illegal, base ops still decode.
    step("noext", JAL, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, h);
    check("noext_jal", 32'({exAluOp0, exAluSrc0, exPcSrcA0, exBranch0, exJump0,
                            exJumpReg0, exIll0}), 32'd1);
    step("noext", LD, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, h);
    check("noext_ld", 32'({exAluOp0, exAluSrc0, exIll0, exRd0}), 32'({2'b00, 1'b1, 1'b0, 5'd8}));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int          k;
      logic [6:0]  op;
      k  = int'($urandom_range(0, 10));
      op = (k < 10) ? tbl[k].op : 7'($urandom);
      step("rnd", op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3), h);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
